// File: rtl/melody_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : melody_sequencer_if
// Brief    : Play request and tone-generator drive bundle for melody_sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface melody_sequencer_if;
    logic       play;
    logic [2:0] melody;
    logic [6:0] sel;
    logic       enable;
    logic       busy;
    logic       done;

    modport master (
        output play, melody,
        input  sel, enable, busy, done
    );

    modport slave (
        input  play, melody,
        output sel, enable, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/melody_sequencer.sv
//------------------------------------------------------------------------------
// Module   : melody_sequencer
// Brief    : Steps through fixed game jingles, driving one-hot note select and
//            enable for the buzzer tone generator with timed tone/gap phases.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module melody_sequencer #(
    parameter int NOTE_TICKS = 10000000,
    parameter int GAP_TICKS  = 1000000
) (
    input  wire logic         CLOCK_50,
    input  wire logic         reset,
    melody_sequencer_if.slave bus
);

    localparam int c_MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int c_CNT_W     = $clog2(c_MAX_TICKS + 1);

    localparam logic [c_CNT_W-1:0] c_NOTE_LAST = c_CNT_W'(NOTE_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [2:0]         c_MAX_CODE  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TONE   = 2'd1,
        S_GAP    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           code_q, code_d;
    logic [2:0]           idx_q, idx_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]           sel_q, sel_d;
    logic                 enable_q, enable_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    function automatic logic [3:0] melody_len(input logic [2:0] code);
        case (code)
            3'd0:    melody_len = 4'd6;
            3'd1:    melody_len = 4'd8;
            3'd2:    melody_len = 4'd2;
            3'd3:    melody_len = 4'd2;
            3'd4:    melody_len = 4'd4;
            default: melody_len = 4'd1;
        endcase
    endfunction

    function automatic logic [2:0] melody_note(input logic [2:0] code, input logic [2:0] idx);
        melody_note = 3'd0;
        case (code)
            3'd0: case (idx)
                3'd0: melody_note = 3'd2;
                3'd1: melody_note = 3'd6;
                3'd2: melody_note = 3'd3;
                3'd3: melody_note = 3'd5;
                3'd4: melody_note = 3'd4;
                default: melody_note = 3'd2;
            endcase
            3'd1: case (idx)
                3'd0, 3'd1, 3'd3: melody_note = 3'd2;
                3'd2:             melody_note = 3'd4;
                default:          melody_note = 3'd6;
            endcase
            3'd2: melody_note = (idx == 3'd0) ? 3'd4 : 3'd6;
            3'd3: melody_note = (idx == 3'd0) ? 3'd1 : 3'd0;
            3'd4: case (idx)
                3'd0: melody_note = 3'd5;
                3'd1: melody_note = 3'd3;
                3'd2: melody_note = 3'd2;
                default: melody_note = 3'd0;
            endcase
            default: melody_note = 3'd0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.play && (bus.melody <= c_MAX_CODE)) begin
                    code_d  = bus.melody;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                    state_d = S_TONE;
                end
            end
            S_TONE: begin
                if (cnt_q == c_NOTE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == c_GAP_LAST) begin
                    cnt_d = '0;
                    if ({1'b0, idx_q} == (melody_len(code_q) - 4'd1)) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_TONE;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so the first tone lands
        // on the edge that samples play.
        sel_d    = (state_d == S_TONE) ? (7'b1 << melody_note(code_d, idx_d)) : 7'd0;
        enable_d = (state_d == S_TONE);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_FINISH);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= S_IDLE;
            code_q   <= 3'd0;
            idx_q    <= 3'd0;
            cnt_q    <= '0;
            sel_q    <= 7'd0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.sel    = sel_q;
    assign bus.enable = enable_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

`default_nettype wire
